// File: rtl/fifo_wr_arbiter_ctrl.sv
// Round-robin write arbiter and pointer controller for a first-word-fall-through FIFO.
// Define FIFO_ARB_ALMOST_EN to add the almost_full / almost_empty outputs.
module fifo_wr_arbiter_ctrl #(
  parameter int unsigned PTR_WIDTH  = 3,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned AF_MARGIN  = 1,
  parameter int unsigned AE_MARGIN  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          r_en,
  output logic                          w_en,
  output logic [PTR_WIDTH-1:0]          waddr,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [PTR_WIDTH-1:0]          raddr,
  output logic                          full,
  output logic                          empty,
  output logic [PTR_WIDTH:0]            count
`ifdef FIFO_ARB_ALMOST_EN
  ,
  output logic                          almost_full,
  output logic                          almost_empty
`endif
);

  localparam int unsigned RrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (DEPTH != (2 ** PTR_WIDTH) || NUM_REQ < 2 || NUM_REQ > 8 ||
      AF_MARGIN > DEPTH || AE_MARGIN > DEPTH) begin : g_param_check
    $error("fifo_wr_arbiter_ctrl: inconsistent parameters");
  end

  logic [PTR_WIDTH:0] wptr_q, wptr_d;
  logic [PTR_WIDTH:0] rptr_q, rptr_d;
  logic [RrW-1:0]     rr_q, rr_d;
  logic [RrW-1:0]     gnt_idx;
  logic               found;
  logic               rd_fire;
  int unsigned        scan_idx;

  // Flags depend only on the registered pointers.
  assign waddr = wptr_q[PTR_WIDTH-1:0];
  assign raddr = rptr_q[PTR_WIDTH-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                 (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
  assign count = wptr_q - rptr_q;

  // Scan upward from rr_q with wrap; first asserted request wins.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    if (rst_n && !full) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = int'(rr_q) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (!found && req[scan_idx]) begin
          found   = 1'b1;
          gnt_idx = RrW'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    gnt     = '0;
    data_in = '0;
    if (found) begin
      gnt     = NUM_REQ'(1) << gnt_idx;
      data_in = req_data[int'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_en    = found;
  assign rd_fire = r_en && !empty;

  always_comb begin
    wptr_d = wptr_q + {{PTR_WIDTH{1'b0}}, w_en};
    rptr_d = rptr_q + {{PTR_WIDTH{1'b0}}, rd_fire};
    rr_d   = rr_q;
    if (found) begin
      rr_d = (gnt_idx == RrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      rr_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      rr_q   <= rr_d;
    end
  end

`ifdef FIFO_ARB_ALMOST_EN
  localparam logic [PTR_WIDTH:0] AfThresh = (PTR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [PTR_WIDTH:0] AeThresh = (PTR_WIDTH + 1)'(AE_MARGIN);

  assign almost_full  = (count >= AfThresh);
  assign almost_empty = (count <= AeThresh);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// Bench for fifo_wr_arbiter_ctrl: directed vector table, corner sequences and a random run
// checked against a queue-based model of the FIFO and round-robin arbitration.
module tb_fifo_wr_arbiter_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        r_en;
  logic        w_en;
  logic [2:0]  waddr;
  logic [7:0]  data_in;
  logic [2:0]  raddr;
  logic        full;
  logic        empty;
  logic [3:0]  count;
`ifdef FIFO_ARB_ALMOST_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  fifo_wr_arbiter_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .r_en     (r_en),
    .w_en     (w_en),
    .waddr    (waddr),
    .data_in  (data_in),
    .raddr    (raddr),
    .full     (full),
    .empty    (empty),
    .count    (count)
`ifdef FIFO_ARB_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage array standing in for fifo_mem.
  logic [7:0] mem [8];
  logic [7:0] data_out;
  always @(posedge clk) if (w_en) mem[waddr] <= data_in;
  assign data_out = mem[raddr];

  int vec;
  int miscmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] rq, input logic re);
    @(negedge clk);
    req  = rq;
    r_en = re;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    r_en  = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       r_en;
    logic [3:0] exp_gnt;
    logic       chk_dout;
    logic [7:0] exp_dout;
    logic [3:0] exp_count;
    logic [2:0] exp_raddr;
  } vec_t;

  vec_t tbl [18];

  // Reference model state
  logic [7:0] q [$];
  int         m_rr;
  int         m_wcnt;
  int         m_rcnt;

  initial begin
    vec    = 0;
    miscmp = 0;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'hF, 1'b0, 4'(1 << (i % 4)), 1'b0, 8'h00, 4'(i + 1), 3'd0};
    tbl[8] = '{4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 4'd8, 3'd0};
    for (int i = 0; i < 8; i++)
      tbl[9 + i] = '{4'h0, 1'b1, 4'h0, 1'b1, 8'(8'hA0 + (i % 4)), 4'(7 - i), 3'((i + 1) % 8)};
    tbl[17] = '{4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 4'd0, 3'd0};

    // Reset held with all requests asserted
    rst_n    = 1'b0;
    req      = 4'hF;
    r_en     = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #3;
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_wen", w_en, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_waddr", waddr, 3'd0);
    chk("rst_raddr", raddr, 3'd0);
`ifdef FIFO_ARB_ALMOST_EN
    chk("rst_afull", almost_full, 1'b0);
    chk("rst_aempty", almost_empty, 1'b1);
`endif
    #4;
    chk("rst_hold_count", count, 4'd0);
    req = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Fill then drain
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].req, tbl[i].r_en);
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp_gnt);
      if (tbl[i].chk_dout) chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].exp_dout);
      tick();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_raddr", i), raddr, tbl[i].exp_raddr);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].exp_count == 4'd8);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_count == 4'd0);
    end

    // Fairness between requesters 1 and 3
    do_reset();
    drive(4'b1010, 1'b0);
    chk("fair0", gnt, 4'b0010);
    tick();
    drive(4'b1010, 1'b0);
    chk("fair1", gnt, 4'b1000);
    tick();
    drive(4'b1010, 1'b0);
    chk("fair2", gnt, 4'b0010);
    tick();

    // Full with simultaneous read: write blocked, granted next cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'hF, 1'b0);
      tick();
    end
    chk("full_pre", full, 1'b1);
    drive(4'b0001, 1'b1);
    chk("full_rd_gnt", gnt, 4'h0);
    tick();
    chk("full_rd_count", count, 4'd7);
    drive(4'b0001, 1'b0);
    chk("full_next_gnt", gnt, 4'b0001);
    tick();
    chk("full_next_count", count, 4'd8);

    // Empty with simultaneous read and write
    do_reset();
    req_data = {8'h33, 8'h22, 8'h11, 8'h5C};
    drive(4'b0001, 1'b1);
    chk("empty_rw_gnt", gnt, 4'b0001);
    chk("empty_rw_din", data_in, 8'h5C);
    tick();
    chk("empty_rw_count", count, 4'd1);
    chk("empty_rw_raddr", raddr, 3'd0);
    chk("empty_rw_dout", data_out, 8'h5C);

    // Reset between edges with 5 entries stored
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 1'b0);
      tick();
    end
    chk("mid_count_pre", count, 4'd5);
    @(negedge clk);
    req = 4'hF;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_empty", empty, 1'b1);
    chk("mid_count", count, 4'd0);
    chk("mid_gnt", gnt, 4'h0);
    rst_n = 1'b1;
    #1;
    chk("mid_rr_restart", gnt, 4'b0001);
    tick();
    chk("mid_count_post", count, 4'd1);

    // Random traffic against the reference model
    do_reset();
    q.delete();
    m_rr   = 0;
    m_wcnt = 0;
    m_rcnt = 0;
    for (int c = 0; c < 600; c++) begin
      logic [3:0] e_gnt;
      logic [7:0] e_din;
      int         g;
      int         rd_pct;
      logic [3:0] rq;
      rd_pct = ((c / 40) % 2 == 0) ? 25 : 80;
      rq     = ((c / 40) % 2 == 0) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
      @(negedge clk);
      req      = rq;
      req_data = $urandom;
      r_en     = ($urandom_range(0, 99) < rd_pct);
      #1;
      g = -1;
      if (q.size() < 8) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && req[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        end
      end
      e_gnt = (g >= 0) ? 4'(1 << g) : 4'h0;
      e_din = (g >= 0) ? req_data[g * 8 +: 8] : 8'h00;
      chk("rnd_gnt", gnt, e_gnt);
      chk("rnd_wen", w_en, g >= 0);
      chk("rnd_din", data_in, e_din);
      chk("rnd_count", count, q.size());
      chk("rnd_full", full, q.size() == 8);
      chk("rnd_empty", empty, q.size() == 0);
      chk("rnd_waddr", waddr, m_wcnt % 8);
      chk("rnd_raddr", raddr, m_rcnt % 8);
      if (q.size() > 0) chk("rnd_dout", data_out, q[0]);
`ifdef FIFO_ARB_ALMOST_EN
      chk("rnd_afull", almost_full, q.size() >= 7);
      chk("rnd_aempty", almost_empty, q.size() <= 1);
`endif
      if (r_en && q.size() > 0) begin
        void'(q.pop_front());
        m_rcnt++;
      end
      if (g >= 0) begin
        q.push_back(e_din);
        m_rr = (g + 1) % 4;
        m_wcnt++;
      end
      @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
